// File: rtl/lcd_parser_pkg.sv
// Shared types and constants for the LCD status-string parser.
// The optional macro LCD_PARSER_LOWERCASE_HEX_EN is consumed by ascii_nibble_decode.
package lcd_parser_pkg;

  typedef enum logic [1:0] {
    PARSE,
    FLUSH,
    HOLD
  } state_t;

  localparam int unsigned TEMPLATE_LEN = 25;

  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

  // One template position: a literal character, or a hex nibble slot.
  typedef struct packed {
    logic [7:0] ch;
    logic       is_nibble;
  } slot_t;

  localparam slot_t NIB = '{8'h00, 1'b1};

  // "CAP=0x" HH " ID=0x" HH "TYPE=0x" HH
  localparam slot_t TEMPLATE [TEMPLATE_LEN] = '{
    '{"C", 1'b0}, '{"A", 1'b0}, '{"P", 1'b0}, '{"=", 1'b0}, '{"0", 1'b0}, '{"x", 1'b0},
    NIB, NIB,
    '{" ", 1'b0}, '{"I", 1'b0}, '{"D", 1'b0}, '{"=", 1'b0}, '{"0", 1'b0}, '{"x", 1'b0},
    NIB, NIB,
    '{"T", 1'b0}, '{"Y", 1'b0}, '{"P", 1'b0}, '{"E", 1'b0}, '{"=", 1'b0}, '{"0", 1'b0},
    '{"x", 1'b0},
    NIB, NIB
  };

  function automatic logic is_terminator(input logic [7:0] c);
    return (c == CHAR_NUL) || (c == CHAR_LF) || (c == CHAR_CR);
  endfunction

endpackage

// File: rtl/ascii_nibble_decode.sv
// Combinational ASCII hex digit to nibble decoder.
// Define LCD_PARSER_LOWERCASE_HEX_EN to also accept 'a'-'f'.
module ascii_nibble_decode (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Digits carry their value in the low nibble; letters are low nibble + 9.
  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (ch >= "0" && ch <= "9") begin
      nibble = ch[3:0];
      is_hex = 1'b1;
    end else if (ch >= "A" && ch <= "F") begin
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`ifdef LCD_PARSER_LOWERCASE_HEX_EN
    else if (ch >= "a" && ch <= "f") begin
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/lcd_string_parser.sv
// Parses "CAP=0xHH ID=0xHHTYPE=0xHH"+terminator into three bytes on a valid/ready port.
// Lowercase hex acceptance is controlled by LCD_PARSER_LOWERCASE_HEX_EN (see ascii_nibble_decode).
module lcd_string_parser
  import lcd_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] memory_capacity,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic       fields_valid,
  input  logic       fields_ready,
  output logic       parse_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [4:0] LAST_POS = 5'(TEMPLATE_LEN);

  state_t      state_q, state_d;
  logic [4:0]  pos_q, pos_d;
  logic [23:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]  cap_d, id_d, type_d;
  logic        fv_d, perr_d;

  logic [3:0]  nibble;
  logic        is_hex;
  slot_t       slot;
  logic        accept, term, match, counting, timeout_hit;

  ascii_nibble_decode u_nibble (
    .ch     (char_in),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign char_ready = (state_q != HOLD);

  // Next-state, position, shadow, timeout and output computation.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    cap_d    = memory_capacity;
    id_d     = manufacture_id;
    type_d   = memory_type;
    fv_d     = fields_valid;
    perr_d   = 1'b0;

    accept   = char_valid && char_ready;
    term     = is_terminator(char_in);
    slot     = (pos_q < LAST_POS) ? TEMPLATE[pos_q] : '0;
    match    = slot.is_nibble ? is_hex : (char_in == slot.ch);
    counting = ((state_q == PARSE) && (pos_q != '0)) || (state_q == FLUSH);
    // Abort on the idle cycle that would bring the counter to TIMEOUT_CYCLES.
    timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !accept && (cnt_q == CNT_LAST);
    cnt_d    = (counting && !accept) ? cnt_q + CNT_W'(1) : '0;

    unique case (state_q)
      PARSE: begin
        if (accept) begin
          if (pos_q == LAST_POS) begin
            if (term) begin
              // The six nibbles were shifted in order, so the shadow is {cap, id, type}.
              cap_d    = shadow_q[23:16];
              id_d     = shadow_q[15:8];
              type_d   = shadow_q[7:0];
              fv_d     = 1'b1;
              state_d  = HOLD;
              pos_d    = '0;
              shadow_d = '0;
            end else begin
              state_d = FLUSH;
            end
          end else if (term) begin
            if (pos_q != '0) begin
              perr_d   = 1'b1;
              pos_d    = '0;
              shadow_d = '0;
            end
          end else if (match) begin
            pos_d = pos_q + 5'd1;
            if (slot.is_nibble) shadow_d = {shadow_q[19:0], nibble};
          end else begin
            state_d = FLUSH;
          end
        end else if (timeout_hit) begin
          perr_d   = 1'b1;
          pos_d    = '0;
          shadow_d = '0;
        end
      end
      FLUSH: begin
        if ((accept && term) || timeout_hit) begin
          perr_d   = 1'b1;
          pos_d    = '0;
          shadow_d = '0;
          state_d  = PARSE;
        end
      end
      HOLD: begin
        if (fields_valid && fields_ready) begin
          fv_d    = 1'b0;
          state_d = PARSE;
          pos_d   = '0;
        end
      end
      default: begin
        state_d  = PARSE;
        pos_d    = '0;
        shadow_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= PARSE;
      pos_q           <= '0;
      shadow_q        <= '0;
      cnt_q           <= '0;
      memory_capacity <= '0;
      manufacture_id  <= '0;
      memory_type     <= '0;
      fields_valid    <= 1'b0;
      parse_error     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pos_q           <= pos_d;
      shadow_q        <= shadow_d;
      cnt_q           <= cnt_d;
      memory_capacity <= cap_d;
      manufacture_id  <= id_d;
      memory_type     <= type_d;
      fields_valid    <= fv_d;
      parse_error     <= perr_d;
    end
  end

endmodule

// File: tb/tb_lcd_string_parser.sv
// Scoreboard bench for lcd_string_parser: expected commits/errors are queued as strings are driven
// and retired by a monitor when the DUT reports them.
module tb_lcd_string_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] memory_capacity;
  logic [7:0] manufacture_id;
  logic [7:0] memory_type;
  logic       fields_valid;
  logic       fields_ready;
  logic       parse_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] cap;
    logic [7:0] id;
    logic [7:0] typ;
  } exp_t;

  exp_t sb[$];

  lcd_string_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .char_in         (char_in),
    .char_valid      (char_valid),
    .char_ready      (char_ready),
    .memory_capacity (memory_capacity),
    .manufacture_id  (manufacture_id),
    .memory_type     (memory_type),
    .fields_valid    (fields_valid),
    .fields_ready    (fields_ready),
    .parse_error     (parse_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ok(input logic [7:0] cap, input logic [7:0] id, input logic [7:0] typ);
    exp_t e;
    e.is_err = 1'b0; e.cap = cap; e.id = id; e.typ = typ;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.cap = '0; e.id = '0; e.typ = '0;
    sb.push_back(e);
  endtask

  // Drive one character; returns #1 after the edge on which it was accepted.
  task automatic send_char(input logic [7:0] c);
    int unsigned n = 0;
    char_in    = c;
    char_valid = 1'b1;
    while (!char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("char_ready_wait", {31'b0, char_ready}, 32'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Monitor: every commit handshake or error pulse retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (parse_error || (fields_valid && fields_ready))) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'b0, fields_valid, parse_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_is_error", {31'b0, parse_error}, {31'b0, e.is_err});
        if (!e.is_err) begin
          check("sb_cap",  {24'b0, memory_capacity}, {24'b0, e.cap});
          check("sb_id",   {24'b0, manufacture_id},  {24'b0, e.id});
          check("sb_type", {24'b0, memory_type},     {24'b0, e.typ});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst_n        = 1'b0;
    char_in      = 8'h00;
    char_valid   = 1'b0;
    fields_ready = 1'b1;
    #3;
    check("rst_char_ready",   {31'b0, char_ready},   32'd1);
    check("rst_fields_valid", {31'b0, fields_valid}, 32'd0);
    check("rst_parse_error",  {31'b0, parse_error},  32'd0);
    check("rst_bytes", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic commit with consumer ready: one-cycle valid, next cycle after terminator.
    expect_ok(8'h1F, 8'hEF, 8'h40);
    send_str("CAP=0x1F ID=0xEFTYPE=0x40");
    send_char(8'h0D);
    check("t1_valid_latency", {31'b0, fields_valid}, 32'd1);
    check("t1_bytes", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'h1FEF40);
    check("t1_no_error", {31'b0, parse_error}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_drop", {31'b0, fields_valid}, 32'd0);

    // Back-pressure: valid held, input stalled, bytes stable.
    fields_ready = 1'b0;
    expect_ok(8'hA5, 8'h3C, 8'h99);
    send_str("CAP=0xA5 ID=0x3CTYPE=0x99");
    send_char(8'h0A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_valid_held", {31'b0, fields_valid}, 32'd1);
      check("t2_ready_low",  {31'b0, char_ready},   32'd0);
      check("t2_bytes_stable", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'hA53C99);
    end
    @(posedge clk);
    #1;
    fields_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_valid_release", {31'b0, fields_valid}, 32'd0);
    check("t2_ready_release", {31'b0, char_ready},   32'd1);

    // Non-hex in a nibble slot: flush to terminator, single error, bytes retained.
    expect_err();
    send_str("CAP=0xG1 ID=0x00TYPE=0x00");
    send_char(8'h0A);
    check("t3_error_pulse", {31'b0, parse_error}, 32'd1);
    @(posedge clk);
    #1;
    check("t3_error_one_cycle", {31'b0, parse_error}, 32'd0);
    check("t3_bytes_kept", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'hA53C99);

    // Leading terminators are ignored; early terminator errors immediately.
    send_char(8'h0D);
    send_char(8'h00);
    check("t4_lead_no_error", {31'b0, parse_error}, 32'd0);
    expect_err();
    send_str("CAP=0x");
    send_char(8'h00);
    check("t4_short_error", {31'b0, parse_error}, 32'd1);
    expect_ok(8'h12, 8'h34, 8'h56);
    send_str("CAP=0x12 ID=0x34TYPE=0x56");
    send_char(8'h00);
    check("t4_commit", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'h123456);

    // Extra character where the terminator belongs.
    expect_err();
    send_str("CAP=0x11 ID=0x22TYPE=0x33X");
    send_char(8'h0D);
    check("t5_overlong_error", {31'b0, parse_error}, 32'd1);
    check("t5_bytes_kept", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'h123456);

    // Mid-string stall: error after exactly TIMEOUT_CYCLES idle cycles.
    expect_err();
    send_str("CAP=0x1");
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (parse_error) break;
    end
    check("t6_timeout_cycles", n, 32'd16);
    expect_ok(8'h7E, 8'h01, 8'hC3);
    send_str("CAP=0x7E ID=0x01TYPE=0xC3");
    send_char(8'h0A);
    check("t6_commit_after_timeout", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'h7E01C3);

    // Lowercase hex digits in nibble slots.
`ifdef LCD_PARSER_LOWERCASE_HEX_EN
    expect_ok(8'hAB, 8'hCD, 8'hEF);
`else
    expect_err();
`endif
    send_str("CAP=0xab ID=0xcdTYPE=0xef");
    send_char(8'h0D);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-string clears everything without events.
    send_str("CAP=0x1");
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_rst_bytes", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'd0);
    check("t8_rst_ready", {31'b0, char_ready},   32'd1);
    check("t8_rst_valid", {31'b0, fields_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_ok(8'h5A, 8'hA5, 8'h0F);
    send_str("CAP=0x5A ID=0xA5TYPE=0x0F");
    send_char(8'h0D);
    check("t8_commit_after_reset", {8'b0, memory_capacity, manufacture_id, memory_type}, 32'h5AA50F);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
